// File: rtl/uc_multiciclo_fsm_pkg.sv
// uc_pkg: shared constants for the multicycle control sequencer.
//   - RV32I-subset opcode / funct constants
//   - state_t: sequencer states
//   - ULAControl codes and mux-select encodings for ResultSrc, ULASrcA, ULASrcB, ImmSrc
//   - trap cause codes
package uc_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BEQ      = 4'd9,
    ST_TRAP     = 4'd10
  } state_t;

  // ULA operations
  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;

  // Result mux
  localparam logic [1:0] RES_ULAOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ULARESULT = 2'b10;

  // ULA A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ULA B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE        = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

endpackage

// File: rtl/uc_multiciclo_fsm_ula_dec.sv
// uc_ula_dec: combinational ALU decode for R-type and I-type arithmetic.
//   op, funct3, funct7 : instruction fields
//   ula_control        : ULA operation code
//   illegal            : funct3/funct7 combination not in the supported subset
// For opcodes other than R/I arithmetic the outputs are add / not-illegal;
// opcode legality is judged by the sequencer itself.
module uc_ula_dec
  import uc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] ula_control,
  output logic       illegal
);

  logic is_r;
  logic is_i;

  assign is_r = (op == OP_RTYPE);
  assign is_i = (op == OP_ITYPE);

  always_comb begin
    ula_control = ULA_ADD;
    illegal     = 1'b0;
    if (is_r || is_i) begin
      case (funct3)
        F3_ADD_SUB: begin
          // I-type funct7 bits are immediate bits, so only R-type looks at them
          if (is_r && funct7 == F7_SUB) begin
            ula_control = ULA_SUB;
          end else if (is_r && funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end
        F3_OR: begin
          ula_control = ULA_OR;
          illegal     = is_r && (funct7 != F7_BASE);
        end
        F3_AND: begin
          ula_control = ULA_AND;
          illegal     = is_r && (funct7 != F7_BASE);
        end
        F3_SLT: begin
          ula_control = ULA_SLT;
          illegal     = is_r && (funct7 != F7_BASE);
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uc_multiciclo_fsm.sv
// uc_multiciclo_fsm: multicycle control sequencer for an RV32I-subset datapath
// (add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq) sharing one ULA and
// one instruction/data memory.
// Ports:
//   clk, rst_n (sync, active-low)
//   OP, Funct3, Funct7 : instruction register fields
//   Zero               : ULA zero flag (beq)
//   Mem_ready          : memory read data valid / write accepted
//   PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite : datapath enables
//   ResultSrc, ULASrcA, ULASrcB, ImmSrc, ULAControl      : datapath selects
//   Trap, Trap_cause   : sticky error flag and its cause
//   Instr_ret          : retired-instruction counter (wraps)
module uc_multiciclo_fsm
  import uc_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       OP,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             Zero,
  input  logic             Mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ULAControl,
  output logic             Trap,
  output logic [1:0]       Trap_cause,
  output logic [CNT_W-1:0] Instr_ret
);

  // State encodings as plain vectors so the state register stays a bare logic
  localparam logic [3:0] S_FETCH    = 4'(ST_FETCH);
  localparam logic [3:0] S_DECODE   = 4'(ST_DECODE);
  localparam logic [3:0] S_MEMADR   = 4'(ST_MEMADR);
  localparam logic [3:0] S_MEMREAD  = 4'(ST_MEMREAD);
  localparam logic [3:0] S_MEMWB    = 4'(ST_MEMWB);
  localparam logic [3:0] S_MEMWRITE = 4'(ST_MEMWRITE);
  localparam logic [3:0] S_EXEC_R   = 4'(ST_EXEC_R);
  localparam logic [3:0] S_EXEC_I   = 4'(ST_EXEC_I);
  localparam logic [3:0] S_ALUWB    = 4'(ST_ALUWB);
  localparam logic [3:0] S_BEQ      = 4'(ST_BEQ);
  localparam logic [3:0] S_TRAP     = 4'(ST_TRAP);

  localparam int              WAIT_W     = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instr_ret_q, instr_ret_d;
  logic              retire;
  logic              mem_wait_state;
  logic              mem_timeout;

  logic [2:0] dec_ula_control;
  logic       dec_illegal;

  // Internal controls before reset gating
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] result_src, ula_src_a, ula_src_b, imm_src;
  logic [2:0] ula_control;

  uc_ula_dec u_ula_dec (
    .op          (OP),
    .funct3      (Funct3),
    .funct7      (Funct7),
    .ula_control (dec_ula_control),
    .illegal     (dec_illegal)
  );

  // Timeout fires only once the counter has already reached the limit and the
  // memory is still not ready; a ready in that cycle takes priority.
  assign mem_timeout = (wait_q == WAIT_LIMIT) && !Mem_ready;

  // Next-state, trap cause and retire
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    retire         = 1'b0;
    mem_wait_state = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_wait_state = 1'b1;
        if (Mem_ready) begin
          state_d = S_DECODE;
        end else if (mem_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (OP)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = dec_illegal ? S_TRAP : S_EXEC_R;
          OP_ITYPE:          state_d = dec_illegal ? S_TRAP : S_EXEC_I;
          OP_BRANCH:         state_d = (Funct3 == F3_BEQ) ? S_BEQ : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) begin
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEMADR: begin
        state_d = (OP == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_wait_state = 1'b1;
        if (Mem_ready) begin
          state_d = S_MEMWB;
        end else if (mem_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end
      S_MEMWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_wait_state = 1'b1;
        if (Mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        // IR is stable since DECODE, so this only guards against a corrupted IR
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Wait counter restarts on every state change
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_wait_state && !Mem_ready) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end

    instr_ret_d = instr_ret_q + CNT_W'(retire);
  end

  // Moore control decode (FETCH and BEQ also look at Mem_ready / Zero)
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ULAOUT;
    ula_src_a   = SRCA_PC;
    ula_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    ula_control = ULA_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        adr_src     = 1'b0;
        ula_src_a   = SRCA_PC;
        ula_src_b   = SRCB_FOUR;
        ula_control = ULA_ADD;
        result_src  = RES_ULARESULT;
        ir_write    = Mem_ready;
        pc_write    = Mem_ready;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ULAOut
        ula_src_a   = SRCA_OLDPC;
        ula_src_b   = SRCB_IMM;
        imm_src     = IMM_B;
        ula_control = ULA_ADD;
      end
      S_MEMADR: begin
        ula_src_a   = SRCA_RS1;
        ula_src_b   = SRCB_IMM;
        imm_src     = (OP == OP_STORE) ? IMM_S : IMM_I;
        ula_control = ULA_ADD;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ula_src_a   = SRCA_RS1;
        ula_src_b   = SRCB_RS2;
        ula_control = dec_ula_control;
      end
      S_EXEC_I: begin
        ula_src_a   = SRCA_RS1;
        ula_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        ula_control = dec_ula_control;
      end
      S_ALUWB: begin
        result_src = RES_ULAOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        ula_src_a   = SRCA_RS1;
        ula_src_b   = SRCB_RS2;
        ula_control = ULA_SUB;
        result_src  = RES_ULAOUT;
        pc_write    = Zero;
      end
      default: begin
        // TRAP and unused encodings keep every control at its default
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      cause_q     <= CAUSE_NONE;
      instr_ret_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cause_q     <= cause_d;
      instr_ret_q <= instr_ret_d;
    end
  end

  // While reset is asserted nothing may be enabled, even if the state register
  // still holds a mid-instruction state.
  assign PCWrite    = rst_n & pc_write;
  assign IRWrite    = rst_n & ir_write;
  assign AdrSrc     = rst_n & adr_src;
  assign MemRead    = rst_n & mem_read;
  assign MemWrite   = rst_n & mem_write;
  assign RegWrite   = rst_n & reg_write;
  assign ResultSrc  = rst_n ? result_src  : 2'b00;
  assign ULASrcA    = rst_n ? ula_src_a   : 2'b00;
  assign ULASrcB    = rst_n ? ula_src_b   : 2'b00;
  assign ImmSrc     = rst_n ? imm_src     : 2'b00;
  assign ULAControl = rst_n ? ula_control : 3'b000;

  assign Trap       = (state_q == S_TRAP);
  assign Trap_cause = cause_q;
  assign Instr_ret  = instr_ret_q;

endmodule

// File: tb/tb_uc_multiciclo_fsm.sv
// Testbench for uc_multiciclo_fsm. Each instruction is described by the
// sequence of control vectors it should produce (one per clock), derived from
// the instruction class, memory wait lengths and Zero. Directed cases first,
// then a randomized instruction stream with occasional illegal encodings.
module tb_uc_multiciclo_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  OP = 7'b0;
  logic [2:0]  Funct3 = 3'b0;
  logic [6:0]  Funct7 = 7'b0;
  logic        Zero = 1'b0;
  logic        Mem_ready = 1'b0;
  logic        PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ULASrcA, ULASrcB, ImmSrc;
  logic [2:0]  ULAControl;
  logic        Trap;
  logic [1:0]  Trap_cause;
  logic [31:0] Instr_ret;

  always #5 clk = ~clk;

  uc_multiciclo_fsm #(.CNT_W(32), .MEM_WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .OP         (OP),
    .Funct3     (Funct3),
    .Funct7     (Funct7),
    .Zero       (Zero),
    .Mem_ready  (Mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ULASrcA    (ULASrcA),
    .ULASrcB    (ULASrcB),
    .ImmSrc     (ImmSrc),
    .ULAControl (ULAControl),
    .Trap       (Trap),
    .Trap_cause (Trap_cause),
    .Instr_ret  (Instr_ret)
  );

  typedef struct packed {
    logic       pcw, irw, adr, mr, mw, rw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] ctl;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
                ResultSrc, ULASrcA, ULASrcB, ImmSrc, ULAControl};

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned model_ret = 0;

  task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t mk(input logic pcw, input logic irw, input logic adr,
                               input logic mr, input logic mw, input logic rw,
                               input logic [1:0] res, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [1:0] imm,
                               input logic [2:0] ctl);
    ctrl_t c;
    c = {pcw, irw, adr, mr, mw, rw, res, sa, sb, imm, ctl};
    return c;
  endfunction

  // ALU decode rules of the instruction subset; returns 1 when the encoding is legal
  function automatic bit alu_model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, output logic [2:0] ctl);
    bit r;
    r   = (op == 7'b0110011);
    ctl = 3'b000;
    case (f3)
      3'b000: begin
        if (r && f7 == 7'b0100000) ctl = 3'b001;
        return !r || f7 == 7'b0000000 || f7 == 7'b0100000;
      end
      3'b110: begin ctl = 3'b011; return !r || f7 == 7'b0; end
      3'b111: begin ctl = 3'b010; return !r || f7 == 7'b0; end
      3'b010: begin ctl = 3'b101; return !r || f7 == 7'b0; end
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive Mem_ready, check the control vector mid-cycle, then advance
  task automatic step(input logic ready, input ctrl_t exp, input bit retire, input string tag);
    Mem_ready = ready;
    @(negedge clk);
    check(32'(obs), 32'(exp), tag);
    @(posedge clk);
    #1;
    if (retire) model_ret++;
  endtask

  // In TRAP everything is idle regardless of inputs
  task automatic check_trap(input logic [1:0] cause, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      Mem_ready = 1'($urandom);
      Zero      = 1'($urandom);
      @(negedge clk);
      check(32'(obs), 32'h0, "trap_ctrl_idle");
      check(32'(Trap), 32'h1, "trap_flag");
      check(32'(Trap_cause), 32'(cause), "trap_cause");
      @(posedge clk);
      #1;
    end
    check(Instr_ret, model_ret, "trap_instr_ret");
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    Mem_ready = 1'($urandom);
    @(negedge clk);
    check(32'(obs), 32'h0, "reset_cycle_ctrl");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_ret = 0;
    check(Instr_ret, 32'h0, "reset_instr_ret");
    check(32'(Trap), 32'h0, "reset_trap");
    check(32'(Trap_cause), 32'h0, "reset_cause");
  endtask

  // Runs one full instruction; fw/mw are wait cycles before Mem_ready in
  // FETCH and in the memory-access step. Reports whether it ended in TRAP.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int fw, input int mw, output bit trapped);
    logic [2:0] ctl;
    bit         legal;
    OP = op; Funct3 = f3; Funct7 = f7; Zero = z;
    trapped = 1'b0;
    for (int i = 0; i < fw; i++)
      step(1'b0, mk(0,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000), 1'b0, "fetch_wait");
    step(1'b1, mk(1,1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000), 1'b0, "fetch");
    step(1'($urandom), mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000), 1'b0, "decode");
    case (op)
      7'b0110011, 7'b0010011: begin
        legal = alu_model(op, f3, f7, ctl);
        if (legal) begin
          if (op == 7'b0110011)
            step(1'($urandom), mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,ctl), 1'b0, "exec_r");
          else
            step(1'($urandom), mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,ctl), 1'b0, "exec_i");
          step(1'($urandom), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000), 1'b1, "aluwb");
        end else begin
          trapped = 1'b1;
        end
      end
      7'b0000011: begin
        step(1'($urandom), mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000), 1'b0, "memadr_lw");
        for (int i = 0; i < mw; i++)
          step(1'b0, mk(0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), 1'b0, "memread_wait");
        step(1'b1, mk(0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), 1'b0, "memread");
        step(1'($urandom), mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000), 1'b1, "memwb");
      end
      7'b0100011: begin
        step(1'($urandom), mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000), 1'b0, "memadr_sw");
        for (int i = 0; i < mw; i++)
          step(1'b0, mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000), 1'b0, "memwrite_wait");
        step(1'b1, mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000), 1'b1, "memwrite");
      end
      7'b1100011: begin
        if (f3 == 3'b000)
          step(1'($urandom), mk(z,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001), 1'b1, "beq");
        else
          trapped = 1'b1;
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      check_trap(2'b01, 3);
    end else begin
      check(Instr_ret, model_ret, "instr_ret");
      check(32'(Trap), 32'h0, "no_trap");
    end
  endtask

  initial begin
    bit         tr;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int         k;

    // Reset state
    do_reset();

    // add x3,x1,x2 with memory always ready: 4 cycles, Instr_ret 0 -> 1
    run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 0, tr);
    check(Instr_ret, 32'd1, "add_retired_one");
    // sub, then lw with 3 wait cycles in MEMREAD, sw with waits
    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1, 0, tr);
    run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 3, tr);
    run_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 2, 2, tr);
    // beq taken / not taken
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0, tr);
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, 0, tr);
    // I-type variants; funct7 field is immediate bits here
    run_instr(7'b0010011, 3'b111, 7'b1010101, 1'b0, 0, 0, tr);
    run_instr(7'b0010011, 3'b010, 7'b0000001, 1'b0, 0, 0, tr);
    // Memory ready exactly at the last tolerated wait cycle: no trap
    run_instr(7'b0110011, 3'b110, 7'b0000000, 1'b0, 15, 0, tr);
    run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 15, tr);

    // Illegal opcode: TRAP cause 01, idle for 20 cycles
    OP = 7'b1111111; Funct3 = 3'b000; Funct7 = 7'b0;
    step(1'b1, mk(1,1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000), 1'b0, "fetch_ill");
    step(1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000), 1'b0, "decode_ill");
    check_trap(2'b01, 20);
    do_reset();

    // Fetch timeout: 16 cycles in FETCH without ready, then TRAP cause 10
    OP = 7'b0110011; Funct3 = 3'b000; Funct7 = 7'b0;
    for (int i = 0; i < 16; i++)
      step(1'b0, mk(0,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000), 1'b0, "fetch_to_wait");
    check_trap(2'b10, 4);
    do_reset();

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 9);
      f7 = 7'b0;
      case (k)
        0, 1, 8: begin
          op = 7'b0110011;
          if (k == 8) begin
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'b0;
          end else begin
            case ($urandom_range(0, 3))
              0: f3 = 3'b000;
              1: f3 = 3'b110;
              2: f3 = 3'b111;
              default: f3 = 3'b010;
            endcase
            if (f3 == 3'b000 && $urandom_range(0, 1) == 1) f7 = 7'b0100000;
          end
        end
        2, 9: begin
          op = 7'b0010011;
          f7 = 7'($urandom);
          f3 = (k == 9) ? 3'($urandom) : 3'b110;
        end
        3: begin op = 7'b0000011; f3 = 3'b010; end
        4: begin op = 7'b0100011; f3 = 3'b010; end
        5, 6: begin op = 7'b1100011; f3 = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b000; end
        default: begin
          op = 7'($urandom);
          f3 = 3'($urandom);
          if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
              op == 7'b0010011 || op == 7'b1100011)
            op = 7'b1111111;
        end
      endcase
      run_instr(op, f3, f7, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), tr);
      if (tr) do_reset();
    end

    // Reset in the middle of MEMWRITE aborts the store
    OP = 7'b0100011; Funct3 = 3'b010; Funct7 = 7'b0;
    step(1'b1, mk(1,1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000), 1'b0, "fetch_sw_rst");
    step(1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000), 1'b0, "decode_sw_rst");
    step(1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000), 1'b0, "memadr_sw_rst");
    step(1'b0, mk(0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000), 1'b0, "memwrite_sw_rst");
    rst_n     = 1'b0;
    Mem_ready = 1'b1;
    @(negedge clk);
    check(32'(MemWrite), 32'h0, "rst_memwrite_low");
    check(32'(obs), 32'h0, "rst_mid_ctrl");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_ret = 0;
    Mem_ready = 1'b0;
    @(negedge clk);
    check(32'(obs), 32'(mk(0,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000)), "rst_back_in_fetch");
    check(Instr_ret, 32'h0, "rst_mid_instr_ret");
    check(32'(Trap), 32'h0, "rst_mid_trap");
    @(posedge clk);
    #1;
    run_instr(7'b0110011, 3'b111, 7'b0000000, 1'b0, 0, 0, tr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
